// File: rtl/riscv_boot_pkg.sv
// Shared types for the instruction-memory boot loader:
// loader FSM states and frame constants.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_e;

  localparam logic [7:0] MAGIC = 8'hA5;

  function automatic logic takes_byte(state_e s);
    return (s != S_RUN) && (s != S_ERROR);
  endfunction

  function automatic logic in_frame(state_e s);
    return (s == S_CNT_LO) || (s == S_CNT_HI) ||
           (s == S_DATA)   || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte idle watchdog: reloads on clear, counts down while
// enabled, and flags expiry on the last allowed idle cycle.
module boot_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: fills imem word by word, verifies the
// XOR checksum and releases the core reset only on a good image.
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        expire;
  logic [15:0] n_word;

  assign in_ready = rst && takes_byte(state_q);
  assign accept   = in_valid && in_ready;
  assign n_word   = {in_data, cnt_q[7:0]};

  boot_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept || !in_frame(state_q)),
    .en_i    (in_frame(state_q)),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wbuf_d  = wbuf_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && (in_data == MAGIC)) begin
          state_d = S_CNT_LO;
          xor_d   = '0;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = in_data;
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d  = n_word;
          idx_d  = '0;
          lane_d = '0;
          if ({1'b0, n_word} > CAP) begin
            state_d = S_ERROR;
          end else if (n_word == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          unique case (lane_q)
            2'd0: wbuf_d[7:0]   = in_data;
            2'd1: wbuf_d[15:8]  = in_data;
            2'd2: wbuf_d[23:16] = in_data;
            2'd3: begin
              we_d    = 1'b1;
              addr_d  = idx_q[ADDR_W-1:0];
              wdata_d = {in_data, wbuf_q};
              idx_d   = idx_q + 16'd1;
              if (idx_q == cnt_q - 16'd1) begin
                state_d = S_CSUM;
              end
            end
            default: ;
          endcase
          lane_d = lane_q + 2'd1;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? S_RUN : S_ERROR;
        end
      end
      default: ;
    endcase
    // A byte landing on the expiry cycle keeps the frame alive.
    if (!accept && expire) begin
      state_d = S_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      wbuf_q  <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wbuf_q  <= wbuf_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = (state_q == S_RUN);
  assign done       = (state_q == S_RUN);
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the imem boot loader: good, bad-checksum,
// garbage-prefixed, oversize, timeout and mid-frame reset loads.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr0;

  imem_boot_loader #(
    .ADDR_W     (AW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h need %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_crst", core_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_rdy", in_ready, 0);
    rst = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rdy", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic [AW-1:0] a);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
    chk("we", imem_we, 1);
    chk("addr", imem_addr, a);
    chk("wdata", imem_wdata, w);
  endtask

  // XOR of 33 01 00 00 B3 01 00 40 is C0
  task automatic good_body();
    send_hdr(16'd2);
    send_word(32'h0000_0133, 0);
    chk("crst_mid", core_rst, 0);
    send_word(32'h4000_01B3, 1);
    chk("crst_lastwr", core_rst, 0);
  endtask

  initial begin
    do_reset();

    wr0 = wr_cnt;
    good_body();
    send(8'hC0);
    idle();
    chk("t1_done", done, 1);
    chk("t1_crst", core_rst, 1);
    chk("t1_err", error, 0);
    chk("t1_we_low", imem_we, 0);
    chk("t1_rdy", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_addr_hold", imem_addr, 1);
    chk("t1_wdata_hold", imem_wdata, 32'h4000_01B3);
    chk("t1_nwr", wr_cnt - wr0, 2);

    do_reset();
    wr0 = wr_cnt;
    good_body();
    send(8'hC1);
    idle();
    chk("t2_err", error, 1);
    chk("t2_crst", core_rst, 0);
    chk("t2_done", done, 0);
    chk("t2_rdy", in_ready, 0);
    chk("t2_nwr", wr_cnt - wr0, 2);

    do_reset();
    wr0 = wr_cnt;
    send(8'h00);
    send(8'hFF);
    chk("t3_garb_err", error, 0);
    good_body();
    send(8'hC0);
    idle();
    chk("t3_done", done, 1);
    chk("t3_crst", core_rst, 1);
    chk("t3_nwr", wr_cnt - wr0, 2);

    do_reset();
    wr0 = wr_cnt;
    send_hdr(16'h0101);
    idle();
    chk("t4_err", error, 1);
    chk("t4_rdy", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_nwr", wr_cnt - wr0, 0);
    chk("t4_crst", core_rst, 0);

    do_reset();
    send_hdr(16'd2);
    send_word(32'h0000_0133, 0);
    send(8'hB3);
    idle();
    repeat (15) @(posedge clk);
    #1;
    chk("t5_err_15", error, 0);
    @(posedge clk);
    #1;
    chk("t5_err_16", error, 1);
    chk("t5_rdy", in_ready, 0);

    do_reset();
    send_hdr(16'd2);
    send_word(32'h0000_0133, 0);
    send(8'hB3);
    idle();
    repeat (15) @(posedge clk);
    #1;
    send(8'h01);
    chk("t5b_err", error, 0);
    send(8'h00);
    send(8'h40);
    chk("t5b_we", imem_we, 1);
    chk("t5b_wdata", imem_wdata, 32'h4000_01B3);
    send(8'hC0);
    idle();
    chk("t5b_done", done, 1);

    do_reset();
    send_hdr(16'd2);
    send_word(32'h0000_0133, 0);
    send(8'hB3);
    send(8'h01);
    do_reset();
    wr0 = wr_cnt;
    good_body();
    send(8'hC0);
    idle();
    chk("t6_done", done, 1);
    chk("t6_crst", core_rst, 1);
    chk("t6_nwr", wr_cnt - wr0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
